scan_cfg_loader: RTL and testbench
==================================

Name: scan_cfg_loader

Overview:
- Configuration sequencer for the fabric scan chain: the serially linked shift_reg, LUT sram and connection-box config cells.
- Accepts the bitstream as parallel words over a valid/ready handshake and serialises each word LSB-first onto the chain head.
- Drives scan_en only on cycles carrying a real bit, counts bits to the chain length, then reports completion.
- Sits between the off-chip/bus config port and the fabric scan_in/scan_out/scan_en nets.

Parameters:
- CHAIN_LEN, 64, total config bits in the fabric chain; must be at least 1.
- WORD_WIDTH, 8, bits per bitstream word.
- CNT_WIDTH, 16, bit-counter width; must satisfy 2**CNT_WIDTH > CHAIN_LEN.

Ports:
- clk  in  1  fabric clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a load when the block is in IDLE or DONE.
- abort  in  1  one-cycle pulse; returns the block to IDLE from any state.
- cfg_data  in  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block can accept a word this cycle.
- scan_out  out  1  serial bit; drives the fabric chain's scan_in.
- scan_en  out  1  chain shift enable; the chain holds its contents when low.
- scan_ret  in  1  tail of the chain (fabric scan_out); used only by the verify feature.
- busy  out  1  load in progress.
- done  out  1  chain fully loaded.
- error  out  1  verify mismatch; stays 0 when the verify feature is compiled out.

Behaviour:
- Reset (async): state IDLE; counters cleared; buffer cleared.
  - All outputs 0: cfg_ready, scan_out, scan_en, busy, done, error.
- States: IDLE, LOAD, SHIFT, DONE, plus VERIFY when the optional feature is compiled in.
- IDLE: a start pulse moves to LOAD and clears bit_cnt, done and error.
- LOAD:
  - cfg_ready=1, busy=1, scan_en=0.
  - On cfg_valid&cfg_ready, cfg_data is captured into the word buffer; SHIFT begins next cycle.
- SHIFT:
  - cfg_ready=0, busy=1, scan_en=1.
  - scan_out = buf[0] (combinational from the buffer register).
  - Each cycle: buffer shifts right, word_bit increments, bit_cnt increments.
  - Next state, evaluated after each shifted bit:
    - bit_cnt reaches CHAIN_LEN: go to DONE (or VERIFY).
    - Otherwise, word_bit reaches WORD_WIDTH: go to LOAD.
- Partial last word: remaining buffer bits are discarded and never shifted; the rest of that word is ignored.
- Timing:
  - One bubble cycle (scan_en=0) per word, while in LOAD.
  - With cfg_valid held high, a full load takes CHAIN_LEN + ceil(CHAIN_LEN/WORD_WIDTH) cycles from the cycle after start until done rises.
  - A stalled cfg_valid simply extends LOAD; the chain is held.
- DONE:
  - done=1, busy=0, scan_en=0, cfg_ready=0.
  - done holds until the next start or abort.
  - start in DONE restarts the load; done drops the cycle after start.
- start while busy: ignored.
- abort (any state): IDLE next cycle; done=0, error=0; chain contents undefined.
  - abort has priority over start and over a simultaneous handshake; the word is not consumed.
- rst mid-load: same as abort, but asynchronous.
- scan_out=0 whenever scan_en=0.

Optional Feature:
- Macro: SCAN_CFG_VERIFY_EN.
- Defined:
  - A running XOR parity is kept over all bits shifted in SHIFT.
  - After the last bit, enter VERIFY for CHAIN_LEN cycles with scan_en=1 and scan_out=scan_ret, recirculating the chain so the configuration is preserved.
  - A second parity accumulates over scan_ret during VERIFY.
  - At exit, error = (parity_in != parity_ret); then enter DONE, with done=1 regardless of error.
  - busy=1 throughout VERIFY.
  - Total load time grows by CHAIN_LEN cycles.
- Undefined:
  - No VERIFY state and no parity registers; error tied 0.
  - scan_ret is unused.

Decomposition:
- Package scan_cfg_pkg holds:
  - the state encoding localparams (ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE, ST_VERIFY);
  - the function computing the word count, ceil(CHAIN_LEN/WORD_WIDTH).
- One natural sub-module: scan_cfg_serializer.
  - Word buffer and word_bit counter.
  - Inputs: load, shift. Outputs: bit, last_bit.
  - The top keeps the FSM, bit_cnt and the verify logic.

Test Plan:
- CHAIN_LEN=16, W=8, words 0xA5 then 0x3C with valid held high.
  - scan_en high on cycles 2-9 and 11-18, with a bubble at cycle 10 (cycle 1 = first LOAD).
  - Serial stream 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - done rises at cycle 19.
  - A 16-bit shift_reg model reads 0x3CA5.
- CHAIN_LEN=12, W=8, words 0xFF then 0x0F.
  - Exactly 12 scan_en cycles.
  - The upper nibble of the second word is never shifted.
  - done=1; the model holds 0xFFF.
- cfg_valid is low for 5 cycles between words.
  - scan_en stays 0 and the chain model is unchanged during the gap.
  - Final contents are identical to the back-to-back case.
- abort asserted in the 4th SHIFT cycle.
  - Next cycle: IDLE, busy=0, scan_en=0, done=0.
  - A subsequent start reloads correctly.
- rst asserted mid-SHIFT, asynchronously between clock edges.
  - All outputs 0 immediately.
  - start ignored while rst is high.
- SCAN_CFG_VERIFY_EN, CHAIN_LEN=16, clean chain model:
  - Expect 16 extra recirculate cycles, error=0, and chain contents preserved.
  - With one bit of the model flipped during VERIFY: error=1 and done=1.

Source files
------------

// File: rtl/scan_cfg_pkg.sv
// Shared definitions for the scan-chain configuration loader: FSM state encoding and
// word-count helper.
package scan_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_VERIFY = 3'd4
  } state_e;

  // Number of bitstream words needed to cover the chain, i.e. ceil(chain_len / word_width).
  function automatic int unsigned word_count(input int unsigned chain_len,
                                             input int unsigned word_width);
    return (chain_len + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/scan_cfg_serializer.sv
// Word buffer for the scan loader: captures one bitstream word and presents it LSB-first,
// flagging the last bit of the word.
module scan_cfg_serializer
  import scan_cfg_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  last_bit
);

  localparam int unsigned WB_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] word_q;
  logic [WB_W-1:0]       word_bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      word_bit_q <= '0;
    end else if (load) begin
      word_q     <= data;
      word_bit_q <= '0;
    end else if (shift) begin
      word_q     <= word_q >> 1;
      word_bit_q <= word_bit_q + WB_W'(1);
    end
  end

  assign ser_bit  = word_q[0];
  assign last_bit = (word_bit_q == WB_W'(WORD_WIDTH - 1));

endmodule

// File: rtl/scan_cfg_loader.sv
// Scan-chain configuration loader: serialises bitstream words onto the fabric chain.
// Define SCAN_CFG_VERIFY_EN to add a parity-checked recirculating readback pass.
module scan_cfg_loader
  import scan_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  scan_out,
  output logic                  scan_en,
  input  logic                  scan_ret,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  if (CHAIN_LEN < 1 || CHAIN_LEN >= (2 ** CNT_WIDTH)) begin : g_param_check
    $error("scan_cfg_loader: CHAIN_LEN must be >= 1 and < 2**CNT_WIDTH");
  end

  state_e               state_q;
  logic [CNT_WIDTH-1:0] bit_cnt_q;
  logic                 cfg_ready_q;
  logic                 scan_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ser_load;
  logic                 ser_shift;
  logic                 ser_bit;
  logic                 last_bit;
  logic                 cnt_last;

  // abort wins over a same-cycle handshake, so the word is left unconsumed.
  assign ser_load  = (state_q == ST_LOAD) && cfg_valid && !abort;
  assign ser_shift = (state_q == ST_SHIFT);
  assign cnt_last  = (bit_cnt_q == CNT_WIDTH'(CHAIN_LEN - 1));

  scan_cfg_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .data    (cfg_data),
    .ser_bit (ser_bit),
    .last_bit(last_bit)
  );

`ifdef SCAN_CFG_VERIFY_EN
  logic error_q;
  logic parity_in_q;
  logic parity_ret_q;
`else
  logic unused_scan_ret;
  assign unused_scan_ret = scan_ret;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_CFG_VERIFY_EN
      error_q     <= 1'b0;
`endif
    end else if (abort) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCAN_CFG_VERIFY_EN
      error_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_LOAD;
            bit_cnt_q   <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef SCAN_CFG_VERIFY_EN
            error_q     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (cfg_valid) begin
            state_q     <= ST_SHIFT;
            cfg_ready_q <= 1'b0;
            scan_en_q   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_last) begin
            // Any bits left in a partial last word are dropped here.
`ifdef SCAN_CFG_VERIFY_EN
            state_q   <= ST_VERIFY;
            bit_cnt_q <= '0;
`else
            state_q   <= ST_DONE;
            bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
            scan_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
`endif
          end else if (last_bit) begin
            state_q     <= ST_LOAD;
            bit_cnt_q   <= bit_cnt_q + CNT_WIDTH'(1);
            scan_en_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
          end
        end
`ifdef SCAN_CFG_VERIFY_EN
        ST_VERIFY: begin
          bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
          if (cnt_last) begin
            state_q   <= ST_DONE;
            scan_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            // Fold in the final returned bit, which the parity register has not seen yet.
            error_q   <= parity_in_q ^ parity_ret_q ^ scan_ret;
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b0;
          scan_en_q   <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_CFG_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_in_q  <= 1'b0;
      parity_ret_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      parity_in_q <= parity_in_q ^ ser_bit;
    end else if (state_q == ST_VERIFY) begin
      parity_ret_q <= parity_ret_q ^ scan_ret;
    end else if (state_q != ST_LOAD) begin
      parity_in_q  <= 1'b0;
      parity_ret_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // scan_out is decoded from the state so it is low whenever scan_en is low.
  always_comb begin
    scan_out = 1'b0;
    if (state_q == ST_SHIFT) begin
      scan_out = ser_bit;
    end
`ifdef SCAN_CFG_VERIFY_EN
    else if (state_q == ST_VERIFY) begin
      scan_out = scan_ret;
    end
`endif
  end

  assign cfg_ready = cfg_ready_q;
  assign scan_en   = scan_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Scoreboard bench for scan_cfg_loader: two instances (16-bit and 12-bit chains) driven with
// directed and random bitstreams; a negedge monitor checks the serial stream and final chain.
module tb_scan_cfg_loader;
  import scan_cfg_pkg::*;

  localparam int unsigned W    = 8;
  localparam int          NDUT = 2;
  localparam int unsigned LEN0 = 16;
  localparam int unsigned LEN1 = 12;
`ifdef SCAN_CFG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NDUT-1:0] start, abort, cfg_valid, cfg_ready, scan_out, scan_en, scan_ret;
  logic [NDUT-1:0] busy, done, error;
  logic [W-1:0]    cfg_data [NDUT];

  logic [63:0] chain     [NDUT];
  bit          exp_bits  [NDUT][$];
  logic [63:0] exp_chain [NDUT][$];
  bit          exp_err   [NDUT][$];
  bit          flip_req  [NDUT];
  logic [NDUT-1:0] done_prev;
  int          en_cnt    [NDUT];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    scan_cfg_loader #(
      .CHAIN_LEN (g == 0 ? LEN0 : LEN1),
      .WORD_WIDTH(W),
      .CNT_WIDTH (16)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .abort    (abort[g]),
      .cfg_data (cfg_data[g]),
      .cfg_valid(cfg_valid[g]),
      .cfg_ready(cfg_ready[g]),
      .scan_out (scan_out[g]),
      .scan_en  (scan_en[g]),
      .scan_ret (scan_ret[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .error    (error[g])
    );
    assign scan_ret[g] = chain[g][0];
  end

  function automatic int unsigned len_of(input int i);
    return (i == 0) ? LEN0 : LEN1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a chain of flops shifting toward bit 0, head at bit len-1, tail (scan_ret) at bit 0.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!busy[i]) en_cnt[i] = 0;
      if (scan_en[i]) begin
        if (flip_req[i] && en_cnt[i] == int'(len_of(i))) begin
          chain[i][len_of(i)-1] = ~chain[i][len_of(i)-1];
          flip_req[i] = 1'b0;
        end
        if (exp_bits[i].size() == 0) begin
          chk($sformatf("dut%0d unexpected scan_en", i), 64'(scan_en[i]), 64'(0));
        end else begin
          bit b;
          b = exp_bits[i].pop_front();
          chk($sformatf("dut%0d scan_out", i), 64'(scan_out[i]), 64'(b));
        end
        chain[i] = (chain[i] >> 1) | (64'(scan_out[i]) << (len_of(i) - 1));
        en_cnt[i]++;
      end else begin
        chk($sformatf("dut%0d scan_out idle", i), 64'(scan_out[i]), 64'(0));
      end
      if (done[i] && !done_prev[i]) begin
        if (exp_chain[i].size() == 0) begin
          chk($sformatf("dut%0d unexpected done", i), 64'(done[i]), 64'(0));
        end else begin
          chk($sformatf("dut%0d chain", i), chain[i], exp_chain[i].pop_front());
          chk($sformatf("dut%0d bits left", i), 64'(exp_bits[i].size()), 64'(0));
          chk($sformatf("dut%0d error", i), 64'(error[i]), 64'(exp_err[i].pop_front()));
        end
      end
      done_prev[i] = done[i];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full load: model the stream, push expectations, then drive the handshake.
  task automatic run_load(input int i, input logic [W-1:0] words[$], input int gap,
                          input bit flip);
    int unsigned len = len_of(i);
    int unsigned nw  = word_count(len, W);
    logic [63:0] stream = '0;
    int cycles = 0;
    int guard;
    for (int k = 0; k < int'(len); k++) stream[k] = words[k / W][k % W];
    for (int k = 0; k < int'(len); k++) exp_bits[i].push_back(stream[k]);
    if (VERIFY) begin
      for (int k = 0; k < int'(len); k++)
        exp_bits[i].push_back(stream[k] ^ (flip && k == int'(len) - 1));
      exp_chain[i].push_back(flip ? (stream ^ (64'(1) << (len - 1))) : stream);
      exp_err[i].push_back(flip);
      flip_req[i] = flip;
    end else begin
      exp_chain[i].push_back(stream);
      exp_err[i].push_back(1'b0);
    end
    cfg_data[i]  = words[0];
    cfg_valid[i] = 1'b1;
    start[i]     = 1'b1;
    cyc();
    start[i] = 1'b0;
    chk($sformatf("dut%0d done after start", i), 64'(done[i]), 64'(0));
    for (int w = 0; w < int'(nw); w++) begin
      cfg_data[i] = words[w];
      if (w > 0 && gap > 0) begin
        guard = 0;
        while (!cfg_ready[i] && guard < 100) begin cyc(); cycles++; guard++; end
        for (int g = 0; g < gap; g++) begin
          chk($sformatf("dut%0d scan_en in gap", i), 64'(scan_en[i]), 64'(0));
          cyc(); cycles++;
        end
      end
      cfg_valid[i] = 1'b1;
      guard = 0;
      while (!cfg_ready[i] && guard < 100) begin cyc(); cycles++; guard++; end
      chk($sformatf("dut%0d cfg_ready w%0d", i, w), 64'(cfg_ready[i]), 64'(1));
      cyc(); cycles++;
      cfg_valid[i] = (gap == 0) && (w + 1 < int'(nw));
    end
    cfg_valid[i] = 1'b0;
    guard = 0;
    while (!done[i] && guard < 200) begin cyc(); cycles++; guard++; end
    chk($sformatf("dut%0d done", i), 64'(done[i]), 64'(1));
    chk($sformatf("dut%0d busy at done", i), 64'(busy[i]), 64'(0));
    if (gap == 0)
      chk($sformatf("dut%0d load cycles", i), 64'(cycles), 64'(len + nw + (VERIFY ? len : 0)));
    cyc();
  endtask

  task automatic rand_words(input int i, output logic [W-1:0] q[$]);
    q = {};
    for (int k = 0; k < int'(word_count(len_of(i), W)); k++) q.push_back(W'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] wq[$];
    int guard;
    start = '0; abort = '0; cfg_valid = '0; done_prev = '0;
    for (int i = 0; i < NDUT; i++) begin
      cfg_data[i] = '0; chain[i] = '0; flip_req[i] = 1'b0; en_cnt[i] = 0;
    end
    rst = 1'b1;
    #3;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("dut%0d rst cfg_ready", i), 64'(cfg_ready[i]), 64'(0));
      chk($sformatf("dut%0d rst scan_en", i), 64'(scan_en[i]), 64'(0));
      chk($sformatf("dut%0d rst scan_out", i), 64'(scan_out[i]), 64'(0));
      chk($sformatf("dut%0d rst busy", i), 64'(busy[i]), 64'(0));
      chk($sformatf("dut%0d rst done", i), 64'(done[i]), 64'(0));
      chk($sformatf("dut%0d rst error", i), 64'(error[i]), 64'(0));
    end
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Directed: 0xA5,0x3C on 16 bits; 0xFF,0x0F on 12 bits; same words with a 5-cycle gap.
    wq = '{8'hA5, 8'h3C};
    run_load(0, wq, 0, 1'b0);
    wq = '{8'hFF, 8'h0F};
    run_load(1, wq, 0, 1'b0);
    wq = '{8'hA5, 8'h3C};
    run_load(0, wq, 5, 1'b0);

    // Abort in the 4th shift cycle.
    for (int k = 0; k < 4; k++) exp_bits[0].push_back(k[0] == 1'b0);
    cfg_data[0] = 8'h55; cfg_valid[0] = 1'b1; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    guard = 0;
    while (!scan_en[0] && guard < 20) begin cyc(); guard++; end
    repeat (3) cyc();
    abort[0] = 1'b1;
    cyc();
    abort[0] = 1'b0; cfg_valid[0] = 1'b0;
    chk("abort busy", 64'(busy[0]), 64'(0));
    chk("abort scan_en", 64'(scan_en[0]), 64'(0));
    chk("abort done", 64'(done[0]), 64'(0));
    chk("abort cfg_ready", 64'(cfg_ready[0]), 64'(0));
    chk("abort bits left", 64'(exp_bits[0].size()), 64'(0));
    rand_words(0, wq);
    run_load(0, wq, 0, 1'b0);

    // Asynchronous reset between edges in the first shift cycle.
    cfg_data[0] = 8'hC3; cfg_valid[0] = 1'b1; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    guard = 0;
    while (!scan_en[0] && guard < 20) begin cyc(); guard++; end
    #2;
    rst = 1'b1;
    #1;
    chk("rst mid cfg_ready", 64'(cfg_ready[0]), 64'(0));
    chk("rst mid scan_en", 64'(scan_en[0]), 64'(0));
    chk("rst mid scan_out", 64'(scan_out[0]), 64'(0));
    chk("rst mid busy", 64'(busy[0]), 64'(0));
    chk("rst mid done", 64'(done[0]), 64'(0));
    cfg_valid[0] = 1'b0;
    cyc();
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    rst = 1'b0;
    repeat (2) cyc();
    chk("start under rst busy", 64'(busy[0]), 64'(0));
    chk("start under rst cfg_ready", 64'(cfg_ready[0]), 64'(0));
    rand_words(0, wq);
    run_load(0, wq, 0, 1'b0);

    // Random bitstreams with random inter-word stalls.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NDUT; i++) begin
        rand_words(i, wq);
        run_load(i, wq, int'($urandom_range(0, 3)), 1'b0);
      end
    end

    if (VERIFY) begin
      rand_words(0, wq);
      run_load(0, wq, 0, 1'b1);
      rand_words(1, wq);
      run_load(1, wq, 0, 1'b1);
    end

    repeat (4) cyc();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("dut%0d bits drained", i), 64'(exp_bits[i].size()), 64'(0));
      chk($sformatf("dut%0d chains drained", i), 64'(exp_chain[i].size()), 64'(0));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
